md_unit_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource used by mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Accepts one operation per start pulse from the EX stage and runs a fixed-latency busy period.
- Commits results to HI/LO at the end of that period.
- Raises a pipeline stall request while a dependent MD instruction waits in decode.

---
 rtl/md_unit_ctrl_if.sv | 15 +
 rtl/md_unit_ctrl.sv | 86 ++++++++
 tb/tb_md_unit_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: EX/ID-side bundle for the HI/LO multiply/divide sequencer
interface md_unit_ctrl_if;
    logic        Start;
    logic [2:0]  MD_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Use_MD;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output Start, MD_Op, A, B, Flush, Use_MD, input Busy, Stall, HI, LO);
    modport slave (input Start, MD_Op, A, B, Flush, Use_MD, output Busy, Stall, HI, LO);
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: HI/LO multiply/divide sequencer with fixed-latency busy period and decode stall
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset_n,
    md_unit_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        commit_q, commit_d;
    logic        accept, is_md, is_mul;
    logic [31:0] b_safe, quo_s, rem_s, quo_u, rem_u;
    logic [63:0] prod_s, prod_u, res;

    assign accept = bus.Start & ~bus.Flush & (state_q == IDLE);
    assign is_md  = bus.MD_Op inside {3'd1, 3'd2, 3'd3, 3'd4};
    assign is_mul = bus.MD_Op inside {3'd1, 3'd2};
    assign b_safe = (bus.B == 32'd0) ? 32'd1 : bus.B;
    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    // 33-bit signed divide so 0x80000000 / -1 wraps to 0x80000000 without overflow
    assign quo_s  = 32'($signed({bus.A[31], bus.A}) / $signed({b_safe[31], b_safe}));
    assign rem_s  = 32'($signed({bus.A[31], bus.A}) % $signed({b_safe[31], b_safe}));
    assign quo_u  = bus.A / b_safe;
    assign rem_u  = bus.A % b_safe;
    assign res    = (bus.MD_Op == 3'd1) ? prod_s :
                    (bus.MD_Op == 3'd2) ? prod_u :
                    (bus.MD_Op == 3'd3) ? {rem_s, quo_s} : {rem_u, quo_u};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        if (state_q == BUSY) begin
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
                hi_d    = commit_q ? pend_hi_q : hi_q;
                lo_d    = commit_q ? pend_lo_q : lo_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (accept) begin
            hi_d = (bus.MD_Op == 3'd5) ? bus.A : hi_q;
            lo_d = (bus.MD_Op == 3'd6) ? bus.A : lo_q;
            if (is_md) begin
                state_d                = BUSY;
                cnt_d                  = is_mul ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
                {pend_hi_d, pend_lo_d} = res;
                commit_d               = is_mul | (bus.B != 32'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
        end
    end

    assign bus.Busy  = (state_q == BUSY);
    assign bus.Stall = bus.Use_MD & ((state_q == BUSY) | (bus.Start & ~bus.Flush & is_md));
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed stimulus checked every cycle against a behavioural HI/LO model
module tb_md_unit_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    md_unit_ctrl_if bus();
    md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int q, r;
        case (op)
            3'd1: return 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'($signed(a)) / int'($signed(b));
                r = int'($signed(a)) % int'($signed(b));
                return {r, q};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    logic        m_commit;
    int          m_left;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi <= 0; m_lo <= 0; m_pend <= 0; m_commit <= 0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_commit) {m_hi, m_lo} <= m_pend;
        end else if (bus.Start && !bus.Flush) begin
            if (bus.MD_Op == 3'd5) m_hi <= bus.A;
            if (bus.MD_Op == 3'd6) m_lo <= bus.A;
            if (bus.MD_Op >= 3'd1 && bus.MD_Op <= 3'd4) begin
                m_left   <= (bus.MD_Op <= 3'd2) ? MULT_N : DIV_N;
                m_commit <= (bus.MD_Op <= 3'd2) || (bus.B != 0);
                m_pend   <= (bus.MD_Op >= 3'd3 && bus.B == 0) ? 64'd0 : md_result(bus.MD_Op, bus.A, bus.B);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            lit("busy", 32'(bus.Busy), 32'(m_left > 0));
            lit("stall", 32'(bus.Stall), 32'(bus.Use_MD && (m_left > 0 ||
                (bus.Start && !bus.Flush && bus.MD_Op >= 3'd1 && bus.MD_Op <= 3'd4))));
            lit("hi", bus.HI, m_hi);
            lit("lo", bus.LO, m_lo);
        end
    end

    task automatic cyc(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic f, input logic u);
        @(negedge clk);
        bus.Start = s; bus.MD_Op = op; bus.A = a; bus.B = b; bus.Flush = f; bus.Use_MD = u;
    endtask

    task automatic wait_idle(input logic u, input logic f, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 3'd0, 0, 0, f, u);
            #2;
            if (!bus.Busy) return;
            n++;
        end
    endtask

    int n;

    initial begin
        bus.Start = 0; bus.MD_Op = 0; bus.A = 0; bus.B = 0; bus.Flush = 0; bus.Use_MD = 0;
        chk_en = 1;
        repeat (2) @(negedge clk);
        reset_n = 1;
        #2;
        lit("rst_busy", 32'(bus.Busy), 0);
        lit("rst_hi", bus.HI, 0);
        lit("rst_lo", bus.LO, 0);
        cyc(1, 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        wait_idle(0, 0, n);
        lit("mult_cycles", n, 5);
        lit("mult_hi", bus.HI, 32'hFFFF_FFFF);
        lit("mult_lo", bus.LO, 32'hFFFF_FFFA);
        cyc(1, 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
        wait_idle(0, 0, n);
        lit("multu_cycles", n, 5);
        lit("multu_hi", bus.HI, 32'h0000_0001);
        lit("multu_lo", bus.LO, 32'hFFFF_FFFE);
        cyc(1, 3'd3, -32'sd7, 32'd2, 0, 1);
        #2;
        lit("stall_issue", 32'(bus.Stall), 1);
        wait_idle(1, 0, n);
        lit("div_cycles", n, 10);
        lit("div_stall_drop", 32'(bus.Stall), 0);
        lit("div_lo", bus.LO, 32'hFFFF_FFFD);
        lit("div_hi", bus.HI, 32'hFFFF_FFFF);
        cyc(1, 3'd5, 32'h11, 0, 0, 0);
        cyc(1, 3'd6, 32'h22, 0, 0, 0);
        #2;
        lit("mthi", bus.HI, 32'h11);
        cyc(0, 3'd0, 0, 0, 0, 0);
        #2;
        lit("mtlo", bus.LO, 32'h22);
        cyc(1, 3'd4, 32'd123, 32'd0, 0, 0);
        wait_idle(0, 0, n);
        lit("divz_cycles", n, 10);
        lit("divz_hi", bus.HI, 32'h11);
        lit("divz_lo", bus.LO, 32'h22);
        cyc(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        wait_idle(0, 0, n);
        lit("ovf_lo", bus.LO, 32'h8000_0000);
        lit("ovf_hi", bus.HI, 32'h0);
        cyc(1, 3'd1, 32'd5, 32'd6, 1, 1);
        #2;
        lit("flush_stall", 32'(bus.Stall), 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        #2;
        lit("flush_busy", 32'(bus.Busy), 0);
        lit("flush_lo", bus.LO, 32'h8000_0000);
        cyc(1, 3'd1, 32'd7, 32'd6, 0, 1);
        cyc(1, 3'd3, 32'd100, 32'd3, 0, 1);
        wait_idle(1, 1, n);
        lit("flushbusy_cycles", n, 4);
        lit("flushbusy_hi", bus.HI, 32'd0);
        lit("flushbusy_lo", bus.LO, 32'd42);
        cyc(1, 3'd3, 32'd100, 32'd7, 0, 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        lit("arst_busy", 32'(bus.Busy), 0);
        lit("arst_hi", bus.HI, 0);
        lit("arst_lo", bus.LO, 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        reset_n = 1;
        repeat (15) cyc(0, 3'd0, 0, 0, 0, 0);
        #2;
        lit("post_busy", 32'(bus.Busy), 0);
        lit("post_hi", bus.HI, 0);
        lit("post_lo", bus.LO, 0);
        chk_en = 0;
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
